led_sequencer: RTL and testbench
================================

# led_sequencer

Pattern controller for the five-LED bank on the 12 MHz iCEstick board. Replaces the free-running counter-to-LED path with a sequenced driver: a prescaler paces the pattern, two debounced push-buttons select the display mode and pause/resume it, and a mode state machine generates the LED word. Sits between the board clock/button pins and the `led[4:0]` pads.

## Interface
- `DIV`, 3000000: prescaler period in clk cycles, giving 4 Hz at 12 MHz; legal range ≥ 2.
- `DEB`, 120000: debounce stability window in clk cycles, giving 10 ms; legal range ≥ 1.
- `clk`  in  1  board clock.
- `rst`  in  1  reset, synchronous, active-low; clock `clk`.
- `btn_mode`  in  1  raw mode button, active-high, asynchronous to `clk`.
- `btn_pause`  in  1  raw pause button, active-high, asynchronous to `clk`.
- `led`  out  5  LED drive word, registered.
- `mode`  out  2  current mode: 0 = COUNT, 1 = SCAN, 2 = BLINK. Value 3 is never produced.
- `running`  out  1  1 = pattern advancing, 0 = paused.
- `tick`  out  1  one-cycle prescaler strobe, registered.

## Operation
- **Input conditioning.** Each button passes through a 2-flop synchronizer and then a debouncer.
  - The debounced level changes only after the synchronized input differs from it for `DEB` consecutive cycles.
  - Any bounce restarts the count.
  - A rising edge of the debounced level produces a one-cycle press pulse.
- **Prescaler.**
  - The counter runs 0..`DIV`-1 and wraps to 0.
  - `tick` = 1 for exactly one cycle when the counter is at `DIV`-1 and `running` = 1.
  - While paused, the counter holds and `tick` stays 0.
- **Mode FSM.** COUNT → SCAN → BLINK → COUNT, advancing on each mode press.
  - On any mode change, the prescaler clears to 0 and the pattern loads the new mode's initial value.
  - A mode change while paused is allowed; `running` is unchanged.
- **Pattern per mode** (advances only on `tick`):
  - COUNT: `led` = 5-bit binary count, initial 0, +1 per tick, wraps 31 → 0.
  - SCAN: one-hot, initial 00001 with direction up.
    - Up shifts left; at 10000 the direction reverses, so the next value is 01000.
    - At 00001 while moving down, the direction reverses to up.
    - Full sequence: 00001, 00010, 00100, 01000, 10000, 01000, …, 00001, 00010.
  - BLINK: initial 11111, toggles with 00000 on each tick.
- **Pause.** Each pause press toggles `running`. The pattern and prescaler state are retained across a pause.
- **Simultaneous events.**
  - Mode and pause presses in the same cycle: both take effect (mode advances with pattern reload, and `running` toggles).
  - Mode press in the same cycle as `tick`: the mode change wins, the pattern loads its initial value, and the tick is discarded.
- **Reset** (`rst` = 0 at a clk edge) forces:
  - `led` = 00000, `mode` = 0, `running` = 1, `tick` = 0.
  - Prescaler = 0, debounced levels = 0, synchronizers = 0, SCAN direction = up.
  - Reset has priority over every other event, including mid-debounce and mid-period.

## Timing
- Press latency: a raw button held high is seen by the synchronizer after 2 cycles. The debounced level rises after `DEB` further cycles, and the press pulse fires on the next cycle. Total from raw edge to pulse is `DEB`+3 cycles; the bench allows ±1.
- A mode press pulse in cycle N gives new `mode` and `led` initial value visible in cycle N+1.
- A pause press pulse in cycle N gives toggled `running` visible in cycle N+1.
- First `tick` after reset or a mode change: `DIV` cycles later. Thereafter period = `DIV` cycles while running.
- `tick` high in cycle N gives the updated `led` value visible in cycle N+1.
- Releasing a button generates no pulse. Holding a button generates exactly one pulse.

## Test plan
All scenarios use `DIV`=4 and `DEB`=3.
- Reset then run: hold `rst` = 0 for 2 cycles, release. Expect `led` = 0, `mode` = 0, `running` = 1. Expect `tick` every 4 cycles, first 4 cycles after release, and `led` counting 1, 2, 3…; after 32 ticks `led` wraps to 0.
- Debounce: pulse `btn_mode` high for 2 cycles, then low. Expect no mode change. Then hold high for 10 cycles. Expect exactly one change to `mode` = 1, `led` = 00001.
- SCAN bounce: in SCAN, let 10 ticks elapse. Expect the sequence 00010, 00100, 01000, 10000, 01000, 00100, 00010, 00001, 00010, 00100.
- BLINK and pause: enter BLINK. Expect `led` = 11111, then 00000 after one tick. Press pause. Expect `running` = 0, no `tick` for 20 cycles, and `led` held. Press pause again. Expect the next tick to arrive after the remaining prescaler cycles.
- Simultaneous presses: release both buttons so their press pulses coincide while in COUNT and running. Expect `mode` = 1, `led` = 00001, `running` = 0.
- Mid-operation reset: in SCAN at `led` = 01000, apply `rst` = 0 for 1 cycle. Expect `led` = 00000, `mode` = 0, `running` = 1, and the next tick 4 cycles after release.

Source files
------------

// File: rtl/led_sequencer_if.sv
// Board-side signal bundle for led_sequencer: raw button pins in, LED bank state out.
interface led_sequencer_if;
    logic       btn_mode;
    logic       btn_pause;
    logic [4:0] led;
    logic [1:0] mode;
    logic       running;
    logic       tick;

    // Driver of the buttons / observer of the LED bank (board or bench).
    modport master (
        output btn_mode,
        output btn_pause,
        input  led,
        input  mode,
        input  running,
        input  tick
    );

    // The sequencer itself.
    modport slave (
        input  btn_mode,
        input  btn_pause,
        output led,
        output mode,
        output running,
        output tick
    );
endinterface

// File: rtl/led_sequencer.sv
// led_sequencer: debounced two-button pattern controller for a five-LED bank.
// A prescaler paces the pattern; the mode button cycles COUNT/SCAN/BLINK and
// the pause button freezes or resumes the pattern and prescaler.
module led_sequencer #(
    parameter int DIV = 3000000,
    parameter int DEB = 120000
) (
    input  logic           clk,
    input  logic           rst,
    led_sequencer_if.slave bus_io
);
    localparam int DIV_W = $clog2(DIV);
    localparam int DEB_W = $clog2(DEB + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB - 1);

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        SCAN  = 2'd1,
        BLINK = 2'd2
    } mode_e;

    // Button vectors: bit 0 = mode button, bit 1 = pause button.
    logic [1:0]            raw_i;
    logic [1:0]            sync1_q;
    logic [1:0]            sync2_q;
    logic [1:0]            deb_q;
    logic [1:0]            deb_d;
    logic [1:0][DEB_W-1:0] deb_cnt_q;
    logic [1:0][DEB_W-1:0] deb_cnt_d;
    logic [1:0]            press_q;
    logic [1:0]            press_d;

    logic                  mode_press;
    logic                  pause_press;

    logic [DIV_W-1:0]      div_cnt_q;
    logic [DIV_W-1:0]      div_cnt_d;
    logic                  tick_q;
    logic                  tick_d;
    logic                  running_q;
    logic                  running_d;

    mode_e                 state_q;
    mode_e                 state_d;
    logic [4:0]            led_q;
    logic [4:0]            led_d;
    logic                  dir_up_q;
    logic                  dir_up_d;

    // Value the LED word takes whenever a mode is (re)entered.
    function automatic logic [4:0] init_led(input mode_e m);
        case (m)
            COUNT:   return 5'b00000;
            SCAN:    return 5'b00001;
            default: return 5'b11111;
        endcase
    endfunction

    // One step of the bouncing one-hot: returns {next direction, next LED word}.
    function automatic logic [5:0] scan_step(input logic [4:0] cur, input logic up);
        if (up) begin
            if (cur[4]) return {1'b0, 5'b01000};
            else        return {1'b1, cur << 1};
        end else begin
            if (cur[0]) return {1'b1, 5'b00010};
            else        return {1'b0, cur >> 1};
        end
    endfunction

    assign raw_i       = {bus_io.btn_pause, bus_io.btn_mode};
    assign mode_press  = press_q[0];
    assign pause_press = press_q[1];

    // Debounce: flip the stable level after DEB consecutive differing samples; any match restarts the count.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        press_d   = '0;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != deb_q[b]) begin
                if (deb_cnt_q[b] == DEB_LAST) begin
                    deb_d[b]   = sync2_q[b];
                    press_d[b] = sync2_q[b];
                end else begin
                    deb_cnt_d[b] = deb_cnt_q[b] + DEB_W'(1);
                end
            end
        end
    end

    // Two-flop synchronizers, debounce state and registered press pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_cnt_q <= '0;
            press_q   <= '0;
        end else begin
            sync1_q   <= raw_i;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            press_q   <= press_d;
        end
    end

    // Prescaler and run flag: a mode change restarts the period and suppresses any pending tick.
    always_comb begin
        div_cnt_d = div_cnt_q;
        tick_d    = 1'b0;
        running_d = running_q ^ pause_press;
        if (mode_press) begin
            div_cnt_d = '0;
        end else if (running_q) begin
            if (div_cnt_q == DIV_LAST) begin
                tick_d    = 1'b1;
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
    end

    // Mode FSM next state: each mode press advances COUNT -> SCAN -> BLINK -> COUNT.
    always_comb begin
        state_d = state_q;
        if (mode_press) begin
            case (state_q)
                COUNT:   state_d = SCAN;
                SCAN:    state_d = BLINK;
                default: state_d = COUNT;
            endcase
        end
    end

    // Pattern generator: reload on mode change, otherwise advance once per tick.
    always_comb begin
        led_d    = led_q;
        dir_up_d = dir_up_q;
        if (mode_press) begin
            led_d    = init_led(state_d);
            dir_up_d = 1'b1;
        end else if (tick_q) begin
            case (state_q)
                COUNT:   led_d = led_q + 5'd1;
                SCAN:    {dir_up_d, led_d} = scan_step(led_q, dir_up_q);
                default: led_d = ~led_q;
            endcase
        end
    end

    // State register for prescaler, run flag, mode and pattern.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            running_q <= 1'b1;
            state_q   <= COUNT;
            led_q     <= 5'b00000;
            dir_up_q  <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            running_q <= running_d;
            state_q   <= state_d;
            led_q     <= led_d;
            dir_up_q  <= dir_up_d;
        end
    end

    assign bus_io.led     = led_q;
    assign bus_io.mode    = state_q;
    assign bus_io.running = running_q;
    assign bus_io.tick    = tick_q;
endmodule

// File: tb/tb_led_sequencer.sv
// Testbench for led_sequencer: directed test-plan scenarios followed by random
// button/reset activity, checked cycle by cycle against a behavioural model.
`timescale 1ns/1ps
module tb_led_sequencer;
    localparam int DIV = 4;
    localparam int DEB = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    led_sequencer_if bus ();

    led_sequencer #(.DIV(DIV), .DEB(DEB)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    typedef struct packed {
        logic [4:0] led;
        logic [1:0] mode;
        logic       running;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state, kept as plain integers.
    bit m_s1[2];
    bit m_s2[2];
    bit m_lvl[2];
    int m_run[2];
    bit m_press[2];
    int m_phase;
    int m_mode;
    int m_step;
    bit m_running;
    bit m_tick;

    // LED word as a function of mode and number of ticks since the mode was entered.
    function automatic logic [4:0] pattern(input int md, input int st);
        case (md)
            0: return 5'((st % 32));
            1: begin
                case (st % 8)
                    0:       return 5'b00001;
                    1, 7:    return 5'b00010;
                    2, 6:    return 5'b00100;
                    3, 5:    return 5'b01000;
                    default: return 5'b10000;
                endcase
            end
            default: return ((st % 2) == 0) ? 5'b11111 : 5'b00000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: advance one clock and queue the outputs expected after this edge.
    always @(posedge clk) begin : model
        bit raw[2];
        bit mp, pp, tk_old, run_old;
        int ph_old;
        exp_t e;
        raw[0] = bus.btn_mode;
        raw[1] = bus.btn_pause;
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_lvl[b] = 1'b0;
                m_run[b] = 0;   m_press[b] = 1'b0;
            end
            m_phase = 0; m_mode = 0; m_step = 0; m_running = 1'b1; m_tick = 1'b0;
        end else begin
            mp      = m_press[0];
            pp      = m_press[1];
            tk_old  = m_tick;
            run_old = m_running;
            ph_old  = m_phase;
            for (int b = 0; b < 2; b++) begin
                m_press[b] = 1'b0;
                if (m_s2[b] != m_lvl[b]) begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == DEB) begin
                        m_lvl[b]   = m_s2[b];
                        m_run[b]   = 0;
                        m_press[b] = m_lvl[b];
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = raw[b];
            end
            m_tick = run_old && (ph_old == DIV - 1) && !mp;
            if (mp) m_phase = 0;
            else if (run_old) m_phase = (ph_old + 1) % DIV;
            if (mp) begin
                m_mode = (m_mode + 1) % 3;
                m_step = 0;
            end else if (tk_old) begin
                m_step = m_step + 1;
            end
            if (pp) m_running = !m_running;
        end
        e.led     = pattern(m_mode, m_step);
        e.mode    = 2'(m_mode);
        e.running = m_running;
        e.tick    = m_tick;
        exp_q.push_back(e);
    end

    // Monitor: compare DUT outputs against the oldest queued expectation, mid-cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            chk("led",     32'(bus.led),     32'(e.led));
            chk("mode",    32'(bus.mode),    32'(e.mode));
            chk("running", 32'(bus.running), 32'(e.running));
            chk("tick",    32'(bus.tick),    32'(e.tick));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_buttons(input bit bm, input bit bp, input int n);
        bus.btn_mode  = bm;
        bus.btn_pause = bp;
        cyc(n);
        bus.btn_mode  = 1'b0;
        bus.btn_pause = 1'b0;
    endtask

    initial begin : stim
        bit found;
        int hold;
        bus.btn_mode  = 1'b0;
        bus.btn_pause = 1'b0;
        rst = 1'b0;

        // Reset then run through more than 32 ticks (COUNT wrap).
        cyc(2);
        chk("reset_led",     32'(bus.led),     32'd0);
        chk("reset_mode",    32'(bus.mode),    32'd0);
        chk("reset_running", 32'(bus.running), 32'd1);
        chk("reset_tick",    32'(bus.tick),    32'd0);
        rst = 1'b1;
        cyc(140);

        // Short glitch is ignored; a long hold gives exactly one mode step.
        hold_buttons(1'b1, 1'b0, 2);
        cyc(10);
        chk("glitch_mode", 32'(bus.mode), 32'd0);
        hold_buttons(1'b1, 1'b0, 10);
        cyc(10);
        chk("held_mode", 32'(bus.mode), 32'd1);

        // SCAN bounce over many ticks.
        cyc(45);

        // BLINK, then pause / resume.
        hold_buttons(1'b1, 1'b0, 8);
        cyc(6);
        chk("blink_mode", 32'(bus.mode), 32'd2);
        cyc(6);
        hold_buttons(1'b0, 1'b1, 8);
        cyc(4);
        chk("paused", 32'(bus.running), 32'd0);
        cyc(20);
        hold_buttons(1'b0, 1'b1, 8);
        cyc(20);

        // Back to COUNT, then simultaneous mode + pause presses.
        hold_buttons(1'b1, 1'b0, 8);
        cyc(6);
        chk("count_mode", 32'(bus.mode), 32'd0);
        hold_buttons(1'b1, 1'b1, 8);
        cyc(8);
        chk("simul_mode",    32'(bus.mode),    32'd1);
        chk("simul_led",     32'(bus.led),     32'd1);
        chk("simul_running", 32'(bus.running), 32'd0);

        // Resume, wait for SCAN at 01000, then reset mid-operation.
        hold_buttons(1'b0, 1'b1, 8);
        cyc(6);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (bus.led == 5'b01000 && bus.mode == 2'd1) found = 1'b1;
            else cyc(1);
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_scan_01000: got led %0h expected 8 within 200 cycles", bus.led);
        end
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        chk("midrst_led",     32'(bus.led),     32'd0);
        chk("midrst_mode",    32'(bus.mode),    32'd0);
        chk("midrst_running", 32'(bus.running), 32'd1);
        cyc(10);

        // Random button activity with occasional resets.
        repeat (300) begin
            bus.btn_mode  = 1'($urandom_range(0, 1));
            bus.btn_pause = 1'($urandom_range(0, 1));
            rst           = ($urandom_range(0, 49) != 0);
            hold          = rst ? int'($urandom_range(1, 8)) : 1;
            cyc(hold);
            rst = 1'b1;
        end
        bus.btn_mode  = 1'b0;
        bus.btn_pause = 1'b0;
        cyc(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
